cpu_reset_seq: RTL and testbench
================================

Name: cpu_reset_seq

Overview:
- Lock-qualified reset sequencer that sits directly downstream of clk_select and runs on its clk_cpu output.
- Consumes the clock-path locked flag and holds the Cortex-M core in reset until the clock has been stable for a programmable time.
- Releases power-on reset (poresetn), then system reset (hresetn), in order.
- Re-asserts both resets whenever lock is lost, and records lock-loss events so capture software can flag glitched runs.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before poresetn releases (min 1).
- PO_TO_SYS_CYCLES, 16: cycles between poresetn release and hresetn release; also the soft-reset pulse width (min 1).
- LOSS_CNT_W, 8: width of the saturating lock-loss counter.
- SYNC_STAGES, 2: flops in the locked synchronizer (min 2).

Ports:
- clk_cpu  input  1  CPU clock from clk_select; sole clock domain.
- resetn  input  1  asynchronous active-low reset.
- locked  input  1  lock flag from clk_select; asynchronous to clk_cpu.
- soft_reset_req  input  1  single-cycle request for a system-only reset.
- clear_status  input  1  single-cycle clear of lock_lost_sticky and lock_loss_cnt.
- poresetn  output  1  core power-on reset, active-low.
- hresetn  output  1  core/bus system reset, active-low.
- cpu_ready  output  1  high only in RUN.
- lock_lost_sticky  output  1  set on any lock loss after the first release.
- lock_loss_cnt  output  LOSS_CNT_W  saturating count of lock-loss events.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous assert, synchronous deassert, active-low, as already decided.
- While resetn=0, all outputs are forced to their reset values:
  - poresetn=0, hresetn=0, cpu_ready=0, lock_lost_sticky=0, lock_loss_cnt=0.
  - State is WAIT_LOCK and the stability counter is 0.
- Synchronizer: locked passes through SYNC_STAGES flops to give locked_s, so latency is SYNC_STAGES cycles. The synchronizer flops also reset to 0.
- All outputs are registered. A state change becomes visible on the outputs one cycle after the deciding edge.
- WAIT_LOCK: poresetn=0, hresetn=0.
  - Counter increments while locked_s=1 and clears to 0 when locked_s=0.
  - When counter==LOCK_STABLE_CYCLES-1 and locked_s=1, go to PO_REL and clear the counter.
- PO_REL: poresetn=1, hresetn=0.
  - Counter increments each cycle.
  - At PO_TO_SYS_CYCLES-1, go to RUN.
- RUN: poresetn=1, hresetn=1, cpu_ready=1.
- SOFT: entered from RUN on soft_reset_req=1.
  - hresetn=0 for exactly PO_TO_SYS_CYCLES cycles, poresetn stays 1, cpu_ready=0.
  - Then return to RUN. soft_reset_req is ignored outside RUN.
- Lock loss: locked_s=0 in PO_REL, RUN or SOFT.
  - Next state is WAIT_LOCK and the counter clears.
  - poresetn=0 and hresetn=0 on the following cycle.
  - lock_lost_sticky is set; lock_loss_cnt increments and saturates at all-ones.
- locked_s=0 in WAIT_LOCK is not a loss event; it only restarts the stability count.
- Simultaneous events:
  - Lock loss beats soft_reset_req.
  - An increment beats clear_status in the same cycle: the result is cnt=1 and sticky=1.
  - clear_status alone zeroes both status outputs next cycle.
- Glitched clk_cpu (trigger-induced) is tolerated only insofar as clk_select drops locked; this block adds no clock monitoring.
- No combinational path from any input to any output.

Decomposition:
- Package cpu_reset_pkg holds:
  - State encoding constants: WAIT_LOCK=2'd0, PO_REL=2'd1, RUN=2'd2, SOFT=2'd3.
  - Counter width function clog2 of max(LOCK_STABLE_CYCLES, PO_TO_SYS_CYCLES).
- One sub-module, cpu_rst_sync: parameterised SYNC_STAGES flop chain with async active-low reset to 0.

Test Plan (LOCK_STABLE_CYCLES=8, PO_TO_SYS_CYCLES=4, SYNC_STAGES=2, LOSS_CNT_W=2):
- Power-up:
  - Stimulus: resetn low 5 cycles, locked=1 throughout, resetn released.
  - Response: poresetn rises 2+8+1 cycles after release; hresetn rises 4 cycles later; cpu_ready=1 with hresetn.
- Unstable lock:
  - Stimulus: locked high 5 cycles, low 1 cycle, high again.
  - Response: stability count restarts; poresetn rises 8 synchronized-high cycles after the final rise; lock_loss_cnt=0.
- Lock loss in RUN:
  - Stimulus: locked drops for 1 cycle.
  - Response: both resets low 2+1 cycles later; sticky=1, cnt=1; full sequence repeats.
- Soft reset:
  - Stimulus: soft_reset_req pulse in RUN.
  - Response: hresetn low exactly 4 cycles, poresetn stays 1.
  - Stimulus: request in the same cycle that locked_s falls.
  - Response: lock-loss path taken.
- Counter saturation and clear:
  - Stimulus: 5 lock losses.
  - Response: cnt saturates at 3.
  - Stimulus: clear_status coincident with a 6th loss.
  - Response: cnt=1, sticky=1.
  - Stimulus: a lone clear_status.
  - Response: cnt=0, sticky=0.
- Reset mid-operation:
  - Stimulus: resetn asserted during PO_REL, then during SOFT.
  - Response: outputs immediately (asynchronously) go to reset values; after release the sequence restarts from WAIT_LOCK.

Source files
------------

// File: rtl/cpu_reset_pkg.sv
// cpu_reset_pkg
//   Shared definitions for the CPU reset sequencer: the sequencer state
//   encoding and the sizing helper for its shared stability/delay counter.
package cpu_reset_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      PO_REL    = 2'd1,
      RUN       = 2'd2,
      SOFT      = 2'd3
   } rst_state_e;

   // Width of a counter that must reach max(a, b) - 1; never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/cpu_rst_sync.sv
// cpu_rst_sync
//   SYNC_STAGES-deep flop chain bringing an asynchronous level into the
//   clk domain. All stages reset to 0, so the output reads "not locked"
//   until the input has been sampled high through the whole chain.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset
//   d      - asynchronous input level
//   q      - synchronized level (latency SYNC_STAGES cycles)
module cpu_rst_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cpu_reset_seq.sv
// cpu_reset_seq
//   Lock-qualified reset sequencer for the Cortex-M core, clocked by clk_cpu
//   from clk_select. Holds the core in reset until the synchronized lock flag
//   has been stable for LOCK_STABLE_CYCLES, releases poresetn, then hresetn
//   PO_TO_SYS_CYCLES later. Any lock loss after the first release drops both
//   resets and is recorded in a sticky flag and a saturating counter.
// Ports:
//   clk_cpu          - sole clock
//   resetn           - asynchronous active-low reset
//   locked           - lock flag from clk_select (asynchronous)
//   soft_reset_req   - one-cycle request for a system-only reset (RUN only)
//   clear_status     - one-cycle clear of the lock-loss status
//   poresetn         - core power-on reset, active-low
//   hresetn          - core/bus system reset, active-low
//   cpu_ready        - high only in RUN
//   lock_lost_sticky - set on any lock loss after the first release
//   lock_loss_cnt    - saturating count of lock-loss events
module cpu_reset_seq
   import cpu_reset_pkg::*;
#(
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned PO_TO_SYS_CYCLES   = 16,
   parameter int unsigned LOSS_CNT_W         = 8,
   parameter int unsigned SYNC_STAGES        = 2
) (
   input  logic                  clk_cpu,
   input  logic                  resetn,
   input  logic                  locked,
   input  logic                  soft_reset_req,
   input  logic                  clear_status,
   output logic                  poresetn,
   output logic                  hresetn,
   output logic                  cpu_ready,
   output logic                  lock_lost_sticky,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

   localparam int unsigned CNT_W = cnt_width(LOCK_STABLE_CYCLES, PO_TO_SYS_CYCLES);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(PO_TO_SYS_CYCLES - 1);

   logic                  locked_s;

   rst_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  poresetn_q, poresetn_d;
   logic                  hresetn_q, hresetn_d;
   logic                  cpu_ready_q, cpu_ready_d;
   logic                  sticky_q, sticky_d;
   logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

   logic                  loss_evt;
   logic                  sticky_base;
   logic [LOSS_CNT_W-1:0] loss_base;

   cpu_rst_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clk   (clk_cpu),
      .rst_n (resetn),
      .d     (locked),
      .q     (locked_s)
   );

   // Next state and shared counter. Lock loss outside WAIT_LOCK overrides
   // every other transition, including a pending soft reset request.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      loss_evt = 1'b0;

      if (state_q != WAIT_LOCK && !locked_s) begin
         loss_evt = 1'b1;
         state_d  = WAIT_LOCK;
         cnt_d    = '0;
      end else begin
         unique case (state_q)
            WAIT_LOCK: begin
               if (!locked_s) begin
                  cnt_d = '0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_d = PO_REL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PO_REL, SOFT: begin
               if (cnt_q == DELAY_LAST) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               if (soft_reset_req) begin
                  state_d = SOFT;
                  cnt_d   = '0;
               end
            end
            default: begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs follow the current state through one register stage, so a
   // transition shows up one cycle after the edge that decided it.
   always_comb begin
      poresetn_d  = (state_q != WAIT_LOCK);
      hresetn_d   = (state_q == RUN);
      cpu_ready_d = (state_q == RUN);
   end

   // Clear is applied first and a same-cycle loss then increments from the
   // cleared value, so a coincident clear and loss leaves cnt=1, sticky=1.
   always_comb begin
      sticky_base = clear_status ? 1'b0 : sticky_q;
      loss_base   = clear_status ? '0 : loss_cnt_q;
      sticky_d    = sticky_base;
      loss_cnt_d  = loss_base;
      if (loss_evt) begin
         sticky_d = 1'b1;
         if (loss_base != '1) begin
            loss_cnt_d = loss_base + LOSS_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_cpu or negedge resetn) begin
      if (!resetn) begin
         state_q     <= WAIT_LOCK;
         cnt_q       <= '0;
         poresetn_q  <= 1'b0;
         hresetn_q   <= 1'b0;
         cpu_ready_q <= 1'b0;
         sticky_q    <= 1'b0;
         loss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         poresetn_q  <= poresetn_d;
         hresetn_q   <= hresetn_d;
         cpu_ready_q <= cpu_ready_d;
         sticky_q    <= sticky_d;
         loss_cnt_q  <= loss_cnt_d;
      end
   end

   assign poresetn         = poresetn_q;
   assign hresetn          = hresetn_q;
   assign cpu_ready        = cpu_ready_q;
   assign lock_lost_sticky = sticky_q;
   assign lock_loss_cnt    = loss_cnt_q;

endmodule

// File: tb/tb_cpu_reset_seq.sv
// tb_cpu_reset_seq
//   Directed bench for cpu_reset_seq with LOCK_STABLE_CYCLES=8,
//   PO_TO_SYS_CYCLES=4, SYNC_STAGES=2, LOSS_CNT_W=2. Expected values are
//   queued as each step is driven and popped when the DUT response is taken.
module tb_cpu_reset_seq;

   localparam int unsigned LSC = 8;
   localparam int unsigned PTS = 4;
   localparam int unsigned SS  = 2;
   localparam int unsigned LW  = 2;

   // Edges from driving locked=1 (or releasing resetn) to poresetn high:
   // SS to synchronize, LSC counted cycles, one output register.
   localparam int unsigned PO_LAT     = SS + LSC + 1;
   // Lock restored one cycle after the drop: measured from the edge on which
   // poresetn fell, the stable count completes after LSC further edges.
   localparam int unsigned RELOCK_LAT = LSC;
   // From the edge after a one-cycle drop is sampled: one more sync stage,
   // the deciding edge, then the output register.
   localparam int unsigned LOSS_LAT   = SS + 1;

   logic          clk_cpu = 1'b0;
   logic          resetn;
   logic          locked;
   logic          soft_reset_req;
   logic          clear_status;
   logic          poresetn;
   logic          hresetn;
   logic          cpu_ready;
   logic          lock_lost_sticky;
   logic [LW-1:0] lock_loss_cnt;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic        po_low_seen;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   cpu_reset_seq #(
      .LOCK_STABLE_CYCLES(LSC),
      .PO_TO_SYS_CYCLES  (PTS),
      .LOSS_CNT_W        (LW),
      .SYNC_STAGES       (SS)
   ) dut (
      .clk_cpu          (clk_cpu),
      .resetn           (resetn),
      .locked           (locked),
      .soft_reset_req   (soft_reset_req),
      .clear_status     (clear_status),
      .poresetn         (poresetn),
      .hresetn          (hresetn),
      .cpu_ready        (cpu_ready),
      .lock_lost_sticky (lock_lost_sticky),
      .lock_loss_cnt    (lock_loss_cnt)
   );

   always #5 clk_cpu = ~clk_cpu;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push(input string t, input logic [31:0] e);
      exp_t x;
      x.tag = t;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t x;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL sb_empty observed=%0d expected=queued_value", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.exp)
         else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", x.tag, obs, x.exp);
         end
      end
   endtask

   function automatic logic out_sel(input int sel);
      case (sel)
         0:       return poresetn;
         1:       return hresetn;
         default: return cpu_ready;
      endcase
   endfunction

   // Counts rising edges until the selected output equals val (sampled 1
   // time unit after each edge). Returns 999 if it never does within 64.
   task automatic wait_for(input int sel, input logic val, output int unsigned n);
      bit done;
      done = 1'b0;
      n    = 999;
      for (int unsigned i = 1; i <= 64 && !done; i++) begin
         @(posedge clk_cpu);
         #1;
         if (poresetn !== 1'b1) po_low_seen = 1'b1;
         if (out_sel(sel) === val) begin
            n    = i;
            done = 1'b1;
         end
      end
   endtask

   task automatic recover();
      int unsigned n;
      push("relock_po", RELOCK_LAT);
      wait_for(0, 1'b1, n);
      check(n);
      push("relock_h", PTS);
      wait_for(1, 1'b1, n);
      check(n);
      push("relock_rdy", 1);
      check(cpu_ready);
   endtask

   // One-cycle lock drop; the caller is left at the negedge after the drop
   // was sampled, with locked restored.
   task automatic lock_drop();
      @(negedge clk_cpu);
      locked = 1'b0;
      @(negedge clk_cpu);
      locked = 1'b1;
   endtask

   task automatic loss_cycle(input int unsigned exp_cnt);
      int unsigned n;
      lock_drop();
      push("loss_fall", LOSS_LAT);
      wait_for(0, 1'b0, n);
      check(n);
      push("loss_hresetn", 0);
      check(hresetn);
      push("loss_sticky", 1);
      check(lock_lost_sticky);
      push("loss_cnt", exp_cnt);
      check(lock_loss_cnt);
      recover();
   endtask

   initial begin
      int unsigned n;
      resetn         = 1'b0;
      locked         = 1'b1;
      soft_reset_req = 1'b0;
      clear_status   = 1'b0;
      po_low_seen    = 1'b0;

      // Reset values
      repeat (5) @(negedge clk_cpu);
      push("rst_po", 0);     check(poresetn);
      push("rst_h", 0);      check(hresetn);
      push("rst_rdy", 0);    check(cpu_ready);
      push("rst_sticky", 0); check(lock_lost_sticky);
      push("rst_cnt", 0);    check(lock_loss_cnt);

      // Power-up with lock held throughout
      resetn = 1'b1;
      push("pwr_po", PO_LAT);
      wait_for(0, 1'b1, n);
      check(n);
      push("pwr_h", PTS);
      wait_for(1, 1'b1, n);
      check(n);
      push("pwr_rdy", 1);    check(cpu_ready);
      push("pwr_sticky", 0); check(lock_lost_sticky);
      push("pwr_cnt", 0);    check(lock_loss_cnt);

      // Soft reset in RUN
      @(negedge clk_cpu);
      soft_reset_req = 1'b1;
      @(posedge clk_cpu);
      #1;
      soft_reset_req = 1'b0;
      po_low_seen    = 1'b0;
      push("soft_fall", 1);
      wait_for(1, 1'b0, n);
      check(n);
      push("soft_rdy_low", 0);
      check(cpu_ready);
      push("soft_low_len", PTS);
      wait_for(1, 1'b1, n);
      check(n);
      push("soft_po_held", 0);
      check(po_low_seen);
      push("soft_rdy_back", 1);
      check(cpu_ready);

      // Lock loss in RUN
      loss_cycle(1);

      // Soft request in the cycle locked_s is low: loss path wins
      @(negedge clk_cpu);
      locked = 1'b0;
      @(negedge clk_cpu);
      locked = 1'b1;
      @(negedge clk_cpu);
      soft_reset_req = 1'b1;
      @(negedge clk_cpu);
      soft_reset_req = 1'b0;
      push("softloss_fall", 1);
      wait_for(0, 1'b0, n);
      check(n);
      push("softloss_cnt", 2);
      check(lock_loss_cnt);
      recover();

      // Losses 3..5: counter saturates at 3
      loss_cycle(3);
      loss_cycle(3);
      loss_cycle(3);

      // Clear coincident with the 6th loss
      @(negedge clk_cpu);
      locked = 1'b0;
      @(negedge clk_cpu);
      locked = 1'b1;
      @(negedge clk_cpu);
      clear_status = 1'b1;
      @(negedge clk_cpu);
      clear_status = 1'b0;
      push("clrloss_fall", 1);
      wait_for(0, 1'b0, n);
      check(n);
      push("clrloss_cnt", 1);    check(lock_loss_cnt);
      push("clrloss_sticky", 1); check(lock_lost_sticky);
      recover();

      // Lone clear
      @(negedge clk_cpu);
      clear_status = 1'b1;
      @(posedge clk_cpu);
      #1;
      clear_status = 1'b0;
      push("clr_cnt", 0);    check(lock_loss_cnt);
      push("clr_sticky", 0); check(lock_lost_sticky);

      // Reset asserted during PO_REL
      lock_drop();
      wait_for(0, 1'b0, n);
      push("porel_sticky_pre", 1);
      check(lock_lost_sticky);
      wait_for(0, 1'b1, n);
      #2;
      resetn = 1'b0;
      #1;
      push("porel_rst_po", 0);     check(poresetn);
      push("porel_rst_sticky", 0); check(lock_lost_sticky);
      push("porel_rst_cnt", 0);    check(lock_loss_cnt);
      @(negedge clk_cpu);
      resetn = 1'b1;
      push("porel_restart_po", PO_LAT);
      wait_for(0, 1'b1, n);
      check(n);
      push("porel_restart_h", PTS);
      wait_for(1, 1'b1, n);
      check(n);

      // Reset asserted during SOFT
      @(negedge clk_cpu);
      soft_reset_req = 1'b1;
      @(posedge clk_cpu);
      #1;
      soft_reset_req = 1'b0;
      @(posedge clk_cpu);
      #1;
      push("softrst_h_pre", 0);  check(hresetn);
      push("softrst_po_pre", 1); check(poresetn);
      #2;
      resetn = 1'b0;
      #1;
      push("softrst_po", 0); check(poresetn);
      push("softrst_h", 0);  check(hresetn);
      @(negedge clk_cpu);
      resetn = 1'b1;
      push("softrst_restart_po", PO_LAT);
      wait_for(0, 1'b1, n);
      check(n);

      // Unstable lock during WAIT_LOCK: count restarts, no loss recorded
      @(negedge clk_cpu);
      resetn = 1'b0;
      locked = 1'b0;
      repeat (2) @(negedge clk_cpu);
      resetn = 1'b1;
      repeat (3) @(negedge clk_cpu);
      locked = 1'b1;
      repeat (5) @(negedge clk_cpu);
      locked = 1'b0;
      @(negedge clk_cpu);
      locked = 1'b1;
      push("unstable_po", PO_LAT);
      wait_for(0, 1'b1, n);
      check(n);
      push("unstable_cnt", 0);    check(lock_loss_cnt);
      push("unstable_sticky", 0); check(lock_lost_sticky);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
